// File: rtl/noc_handshake_adapter_pkg.sv
// Shared constants and types for the NoC avail/valid handshake adapters (tx and rx side).
// Also provides the avail-grant helper used to compute the sender permission.
package noc_handshake_adapter_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 32'd64;
    localparam int unsigned DEFAULT_FIFO_DEPTH = 32'd4;
    localparam int unsigned AVAIL_MARGIN       = 32'd2;

    typedef logic [DEFAULT_DATA_WIDTH-1:0] flit_t;

    // Grant when the free slots still cover one flit possibly in flight plus one more.
    function automatic logic avail_grant(input int unsigned depth, input int unsigned occupancy);
        logic grant_s;
        if (depth >= occupancy + AVAIL_MARGIN) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
        return grant_s;
    endfunction

endpackage

// File: rtl/noc_adapter_fifo.sv
// Register-array FIFO with naturally wrapping pointers and an occupancy counter.
// A push while full is only accepted when a pop frees a slot in the same cycle.
module noc_adapter_fifo
    import noc_handshake_adapter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic [DATA_WIDTH-1:0]        wdata_i,
    output logic [DATA_WIDTH-1:0]        rdata_o,
    output logic [$clog2(FIFO_DEPTH):0]  count_next_o,
    output logic                         empty_o,
    output logic                         full_o
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef logic [DATA_WIDTH-1:0] data_t;

    data_t            mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             empty_s, full_s, pop_s, wr_en_s;

    assign empty_s = (count_q == {CNT_W{1'b0}});
    assign full_s  = (count_q == DEPTH_C);
    assign pop_s   = pop_i & ~empty_s;
    // A full push is dropped unless the same cycle pops.
    assign wr_en_s = push_i & (~full_s | pop_s);

    // Next-state for pointers and occupancy.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1'b1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1'b1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({wr_en_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1'b1);
            2'b01:   count_d = count_q - CNT_W'(1'b1);
            default: count_d = count_q;
        endcase
    end

    // Control state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array, intentionally not reset.
    always_ff @(posedge clk_i) begin
        if (wr_en_s) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o      = mem_q[rd_ptr_q];
    assign count_next_o = count_d;
    assign empty_o      = empty_s;
    assign full_o       = full_s;

endmodule

// File: rtl/noc_handshake2validready_adapter_chk.sv
// Protocol checker for the receive adapter: noc_valid_i must follow a cycle with noc_avail_o high.
// Compiled only when NOC2VR_OVERFLOW_CHECK_EN is defined.
`ifdef NOC2VR_OVERFLOW_CHECK_EN
module noc_handshake2validready_adapter_chk (
    input logic clk_i,
    input logic rst_ni,
    input logic noc_valid_i,
    input logic noc_avail_o
);

    logic avail_prev_q;

    // Remember last cycle's grant.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            avail_prev_q <= 1'b0;
        end else begin
            avail_prev_q <= noc_avail_o;
        end
    end

    property p_valid_needs_avail;
        @(posedge clk_i) disable iff (!rst_ni) noc_valid_i |-> avail_prev_q;
    endproperty

    a_valid_needs_avail: assert property (p_valid_needs_avail)
        else $error("noc_valid_i asserted without noc_avail_o in the previous cycle");

endmodule
`endif

// File: rtl/noc_handshake2validready_adapter.sv
// Receive-side adapter: NoC avail/valid flits into a valid/ready consumer via a small FIFO.
// Optional NOC2VR_OVERFLOW_CHECK_EN adds the sticky overflow flag and the protocol checker.
module noc_handshake2validready_adapter
    import noc_handshake_adapter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [DATA_WIDTH-1:0] noc_data_i,
    input  logic                  noc_valid_i,
    output logic                  noc_avail_o,
    output logic [DATA_WIDTH-1:0] m_data_o,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic                  overflow_o
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [CNT_W-1:0] count_next_s;
    logic             empty_s, full_s, pop_s;
    logic             avail_q, avail_d;

    assign pop_s = ~empty_s & m_ready_i;

    noc_adapter_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .push_i       (noc_valid_i),
        .pop_i        (pop_s),
        .wdata_i      (noc_data_i),
        .rdata_o      (m_data_o),
        .count_next_o (count_next_s),
        .empty_o      (empty_s),
        .full_o       (full_s)
    );

    // Grant ignores next cycle's pop, so it may stay low one cycle longer than needed.
    always_comb begin
        avail_d = avail_grant(FIFO_DEPTH, 32'(count_next_s));
    end

    // Avail register; comes up on the first edge after reset release.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            avail_q <= 1'b0;
        end else begin
            avail_q <= avail_d;
        end
    end

    assign noc_avail_o = avail_q;
    assign m_valid_o   = ~empty_s;

`ifdef NOC2VR_OVERFLOW_CHECK_EN
    logic overflow_q, overflow_d;

    // Sticky overflow: a full push with no pop is dropped by the FIFO.
    always_comb begin
        if (noc_valid_i & full_s & ~pop_s) begin
            overflow_d = 1'b1;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // Overflow flag register, cleared only by reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign overflow_o = overflow_q;

    noc_handshake2validready_adapter_chk u_chk (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .noc_valid_i (noc_valid_i),
        .noc_avail_o (avail_q)
    );
`else
    logic unused_full_s;
    assign unused_full_s = full_s;
    assign overflow_o    = 1'b0;
`endif

endmodule

// File: tb/tb_noc_handshake2validready_adapter.sv
// Directed self-checking bench for noc_handshake2validready_adapter (DATA_WIDTH=64, FIFO_DEPTH=4).
module tb_noc_handshake2validready_adapter;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [63:0] noc_data_i;
    logic        noc_valid_i;
    logic        noc_avail_o;
    logic [63:0] m_data_o;
    logic        m_valid_o;
    logic        m_ready_i;
    logic        overflow_o;

    int   n_cmp = 0;
    int   n_err = 0;
    logic avail_last;
    logic avail_prev;
    int   sent;

`ifdef NOC2VR_OVERFLOW_CHECK_EN
    localparam logic OVF_EXP = 1'b1;
`else
    localparam logic OVF_EXP = 1'b0;
`endif

    noc_handshake2validready_adapter #(
        .DATA_WIDTH (64),
        .FIFO_DEPTH (4)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .noc_data_i  (noc_data_i),
        .noc_valid_i (noc_valid_i),
        .noc_avail_o (noc_avail_o),
        .m_data_o    (m_data_o),
        .m_valid_o   (m_valid_o),
        .m_ready_i   (m_ready_i),
        .overflow_o  (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge and track the last two observed avail values.
    task automatic sync();
        @(negedge clk_i);
        avail_prev = avail_last;
        avail_last = noc_avail_o;
    endtask

    initial begin
        logic exp_av [6];
        logic exp_dr [4];
        exp_av = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        exp_dr = '{1'b0, 1'b0, 1'b1, 1'b1};

        rst_ni      = 1'b0;
        noc_valid_i = 1'b0;
        noc_data_i  = 64'd0;
        m_ready_i   = 1'b0;
        avail_last  = 1'b0;
        avail_prev  = 1'b0;
        sent        = 0;

        // Reset state
        sync();
        sync();
        chk_eq("rst_avail", 64'(noc_avail_o), 64'd0);
        chk_eq("rst_mvalid", 64'(m_valid_o), 64'd0);
        chk_eq("rst_ovf", 64'(overflow_o), 64'd0);
        rst_ni = 1'b1;
        sync();
        chk_eq("post_rst_avail", 64'(noc_avail_o), 64'd1);
        chk_eq("post_rst_mvalid", 64'(m_valid_o), 64'd0);
        chk_eq("post_rst_ovf", 64'(overflow_o), 64'd0);

        // Single flit, one-cycle latency, present for one cycle
        m_ready_i   = 1'b1;
        noc_valid_i = 1'b1;
        noc_data_i  = 64'hA5;
        sync();
        noc_valid_i = 1'b0;
        chk_eq("single_mvalid", 64'(m_valid_o), 64'd1);
        chk_eq("single_data", m_data_o, 64'hA5);
        sync();
        chk_eq("single_gone", 64'(m_valid_o), 64'd0);

        // Streaming 16 flits at full rate; avail must never drop
        for (int i = 0; i <= 16; i++) begin
            if (i > 0) begin
                chk_eq("stream_mvalid", 64'(m_valid_o), 64'd1);
                chk_eq("stream_data", m_data_o, 64'(i - 1));
            end
            chk_eq("stream_avail", 64'(noc_avail_o), 64'd1);
            if (i < 16) begin
                noc_valid_i = 1'b1;
                noc_data_i  = 64'(i);
            end else begin
                noc_valid_i = 1'b0;
            end
            sync();
        end
        chk_eq("stream_empty", 64'(m_valid_o), 64'd0);
        chk_eq("stream_end_avail", 64'(noc_avail_o), 64'd1);

        // Consumer stalled, sender honours avail
        m_ready_i = 1'b0;
        for (int s = 0; s < 6; s++) begin
            chk_eq("stall_avail", 64'(noc_avail_o), 64'(exp_av[s]));
            chk_eq("stall_mvalid", 64'(m_valid_o), (s > 0) ? 64'd1 : 64'd0);
            if (avail_prev) begin
                noc_valid_i = 1'b1;
                noc_data_i  = 64'h100 + 64'(sent);
                sent++;
            end else begin
                noc_valid_i = 1'b0;
            end
            sync();
        end
        noc_valid_i = 1'b0;
        chk_eq("stall_sent", 64'(sent), 64'd4);
        chk_eq("stall_head", m_data_o, 64'h100);
        chk_eq("stall_mvalid_full", 64'(m_valid_o), 64'd1);

        // Full FIFO: push and pop together, then drain
        m_ready_i   = 1'b1;
        noc_valid_i = 1'b1;
        noc_data_i  = 64'h104;
        sync();
        noc_valid_i = 1'b0;
        for (int d = 0; d < 4; d++) begin
            chk_eq("drain_mvalid", 64'(m_valid_o), 64'd1);
            chk_eq("drain_data", m_data_o, 64'h101 + 64'(d));
            chk_eq("drain_avail", 64'(noc_avail_o), 64'(exp_dr[d]));
            chk_eq("drain_ovf", 64'(overflow_o), 64'd0);
            sync();
        end
        chk_eq("drain_empty", 64'(m_valid_o), 64'd0);
        chk_eq("drain_avail_back", 64'(noc_avail_o), 64'd1);

        // Protocol violation: push while full with no pop
        m_ready_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            noc_valid_i = 1'b1;
            noc_data_i  = 64'h200 + 64'(k);
            sync();
        end
        noc_data_i = 64'h2FF;
        sync();
        noc_valid_i = 1'b0;
        chk_eq("ovf_set", 64'(overflow_o), 64'(OVF_EXP));
        chk_eq("ovf_head", m_data_o, 64'h200);
        sync();
        chk_eq("ovf_sticky", 64'(overflow_o), 64'(OVF_EXP));
        m_ready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk_eq("ovf_drain_mvalid", 64'(m_valid_o), 64'd1);
            chk_eq("ovf_drain_data", m_data_o, 64'h200 + 64'(k));
            sync();
        end
        chk_eq("ovf_dropped", 64'(m_valid_o), 64'd0);
        chk_eq("ovf_still_set", 64'(overflow_o), 64'(OVF_EXP));

        // Reset asserted mid-burst clears state immediately
        m_ready_i   = 1'b0;
        noc_valid_i = 1'b1;
        noc_data_i  = 64'h300;
        sync();
        noc_data_i = 64'h301;
        sync();
        chk_eq("burst_mvalid", 64'(m_valid_o), 64'd1);
        chk_eq("burst_avail", 64'(noc_avail_o), 64'd1);
        rst_ni = 1'b0;
        #1;
        chk_eq("async_rst_mvalid", 64'(m_valid_o), 64'd0);
        chk_eq("async_rst_avail", 64'(noc_avail_o), 64'd0);
        chk_eq("async_rst_ovf", 64'(overflow_o), 64'd0);
        noc_valid_i = 1'b0;
        sync();
        rst_ni = 1'b1;
        sync();
        chk_eq("rerst_avail", 64'(noc_avail_o), 64'd1);
        chk_eq("rerst_mvalid", 64'(m_valid_o), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
